// File: rtl/rom_port_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : rom_port_arbiter
// Description : Shares one single-port image ROM between N_REQ fetch
//               requesters. Round-robin arbitration with an optional
//               strict-priority override for requester 0. The granted
//               requester is tracked through the ROM read latency by a
//               one-hot tag pipeline, and the returned data is presented
//               with a one-hot valid strobe to the requester that issued it.
// Revision    : 1.0 - initial release
// ============================================================================
module rom_port_arbiter #(
  parameter int N_REQ   = 4,   // number of requesters (2..8)
  parameter int ADDR_W  = 16,  // ROM address width
  parameter int DATA_W  = 12,  // ROM data width
  parameter int ROM_LAT = 2    // registered rom_en/rom_addr to valid rom_data (1..4)
) (
  input  logic                      clk,
  input  logic                      rst,       // asynchronous, active low
  input  logic [N_REQ-1:0]          req,
  input  logic [N_REQ*ADDR_W-1:0]   addr_in,
  input  logic                      prio_en,
  output logic [N_REQ-1:0]          gnt,
  output logic                      rom_en,
  output logic [ADDR_W-1:0]         rom_addr,
  input  logic [DATA_W-1:0]         rom_data,
  output logic [N_REQ-1:0]          rd_valid,
  output logic [DATA_W-1:0]         rd_data
);

  localparam int PTR_W = (N_REQ > 1) ? $clog2(N_REQ) : 1;
  localparam logic [PTR_W-1:0] C_LAST_IDX = PTR_W'(N_REQ - 1);

  // Round-robin pointer: first requester examined in the next search.
  logic [PTR_W-1:0] r_rr_ptr;

  // Arbitration result for the current cycle.
  logic             w_gnt_any;
  logic [PTR_W-1:0] w_gnt_idx;
  logic [N_REQ-1:0] w_gnt;
  logic [ADDR_W-1:0] w_gnt_addr;

  // One-hot tags following each issued read through the ROM latency.
  logic [N_REQ-1:0] r_tag [ROM_LAT];

  // Requester index reached by stepping 'off' places from 'base', wrapping
  // at N_REQ (N_REQ need not be a power of two).
  function automatic logic [PTR_W-1:0] wrap_idx(input logic [PTR_W-1:0] base,
                                                input int off);
    int sum;
    sum = int'(base) + off;
    if (sum >= N_REQ) begin
      sum = sum - N_REQ;
    end
    return PTR_W'(sum);
  endfunction

  // Grant selection: priority override for requester 0, otherwise the first
  // requesting index at or after the round-robin pointer. Nothing is granted
  // while reset is held so a pending request cannot slip through.
  always_comb begin
    w_gnt_any = 1'b0;
    w_gnt_idx = '0;
    w_gnt     = '0;
    if (rst) begin
      if (prio_en && req[0]) begin
        w_gnt_any = 1'b1;
        w_gnt_idx = '0;
      end else begin
        for (int off = 0; off < N_REQ; off++) begin
          if (!w_gnt_any && req[wrap_idx(r_rr_ptr, off)]) begin
            w_gnt_any = 1'b1;
            w_gnt_idx = wrap_idx(r_rr_ptr, off);
          end
        end
      end
      if (w_gnt_any) begin
        w_gnt[w_gnt_idx] = 1'b1;
      end
    end
  end

  assign gnt = w_gnt;

  // Address of the winning requester, picked from the packed address bus.
  always_comb begin
    w_gnt_addr = addr_in[w_gnt_idx*ADDR_W +: ADDR_W];
  end

  // Pointer moves just past the winner (priority grants included); it holds
  // when nothing is granted.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_rr_ptr <= '0;
    end else if (w_gnt_any) begin
      r_rr_ptr <= (w_gnt_idx == C_LAST_IDX) ? '0 : w_gnt_idx + 1'b1;
    end
  end

  // Issue stage: register the ROM read for the accepted request. The address
  // holds across idle cycles so the ROM bus does not toggle needlessly.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      rom_en   <= 1'b0;
      rom_addr <= '0;
    end else begin
      rom_en <= w_gnt_any;
      if (w_gnt_any) begin
        rom_addr <= w_gnt_addr;
      end
    end
  end

  // Tag stage 0 captures who was granted alongside the issue registers.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_tag[0] <= '0;
    end else begin
      r_tag[0] <= w_gnt;
    end
  end

  // Remaining tag stages shift every cycle; the ROM never stalls, so the
  // tag arrives at the last stage exactly when its data is on rom_data.
  generate
    for (genvar s = 1; s < ROM_LAT; s++) begin : g_tag_stage
      // Shift one tag stage forward.
      always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
          r_tag[s] <= '0;
        end else begin
          r_tag[s] <= r_tag[s-1];
        end
      end
    end
  endgenerate

  // Return stage: strobe the owner and capture data only for real returns,
  // so rd_data keeps the last delivered pixel during idle cycles.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      rd_valid <= '0;
      rd_data  <= '0;
    end else begin
      rd_valid <= r_tag[ROM_LAT-1];
      if (|r_tag[ROM_LAT-1]) begin
        rd_data <= rom_data;
      end
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_rom_port_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : tb_rom_port_arbiter
// Description : Directed bench for rom_port_arbiter with a simple ROM model
//               (data = ~address) and a cycle-stamped return scoreboard.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_rom_port_arbiter;

  logic        clk = 1'b0;
  logic        rst;
  logic [3:0]  req;
  logic [63:0] addr_in;
  logic        prio_en;
  logic [3:0]  gnt;
  logic        rom_en;
  logic [15:0] rom_addr;
  logic [11:0] rom_data;
  logic [3:0]  rd_valid;
  logic [11:0] rd_data;

  logic [15:0] a [4];
  assign addr_in = {a[3], a[2], a[1], a[0]};

  always #5 clk = ~clk;

  rom_port_arbiter #(
    .N_REQ  (4),
    .ADDR_W (16),
    .DATA_W (12),
    .ROM_LAT(2)
  ) dut (
    .clk     (clk),
    .rst     (rst),
    .req     (req),
    .addr_in (addr_in),
    .prio_en (prio_en),
    .gnt     (gnt),
    .rom_en  (rom_en),
    .rom_addr(rom_addr),
    .rom_data(rom_data),
    .rd_valid(rd_valid),
    .rd_data (rd_data)
  );

  // Synchronous ROM with one output register: data for an address issued
  // on cycle t+1 is on rom_data during cycle t+2.
  logic [11:0] rom_q = '0;
  always @(posedge clk) begin
    if (rom_en) rom_q <= ~rom_addr[11:0];
  end
  assign rom_data = rom_q;

  typedef struct {
    int         due;
    logic [3:0] vld;
    logic [11:0] data;
  } sb_t;
  sb_t sb_q[$];

  int vectors     = 0;
  int miscompares = 0;
  int cyc         = 0;

  logic        exp_en    = 1'b0;
  logic [15:0] exp_addr  = '0;
  logic [11:0] exp_rdata = '0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // One clock cycle: apply inputs, check the combinational grant against the
  // directed expectation, then after the edge check issue and return ports.
  task automatic step(input logic [3:0] r, input logic p, input logic [3:0] eg,
                      input string tag);
    int  k;
    sb_t e;
    req     = r;
    prio_en = p;
    #2;
    chk({tag, "/gnt"}, 32'(gnt), 32'(eg));
    k = -1;
    for (int i = 0; i < 4; i++) if (eg[i]) k = i;
    if (k >= 0) begin
      exp_en   = 1'b1;
      exp_addr = a[k];
      e.due    = cyc + 3;
      e.vld    = eg;
      e.data   = ~a[k][11:0];
      sb_q.push_back(e);
    end else begin
      exp_en = 1'b0;
    end
    @(posedge clk);
    cyc++;
    #1;
    if (k >= 0) a[k] = a[k] + 16'h0111;
    chk({tag, "/rom_en"},   32'(rom_en),   32'(exp_en));
    chk({tag, "/rom_addr"}, 32'(rom_addr), 32'(exp_addr));
    if (sb_q.size() > 0 && sb_q[0].due == cyc) begin
      e = sb_q.pop_front();
      exp_rdata = e.data;
      chk({tag, "/rd_valid"}, 32'(rd_valid), 32'(e.vld));
    end else begin
      chk({tag, "/rd_valid_idle"}, 32'(rd_valid), 32'(0));
    end
    chk({tag, "/rd_data"}, 32'(rd_data), 32'(exp_rdata));
  endtask

  task automatic idle(input int n, input string tag);
    for (int i = 0; i < n; i++) step(4'b0000, 1'b0, 4'b0000, tag);
  endtask

  initial begin
    rst     = 1'b1;
    req     = 4'b0000;
    prio_en = 1'b0;
    a[0] = 16'h0A0A; a[1] = 16'h1B1B; a[2] = 16'h1234; a[3] = 16'h3C3C;

    // Power-on reset with requests pending: nothing may be granted.
    #2;
    rst = 1'b0;
    req = 4'b1111;
    repeat (2) begin @(posedge clk); cyc++; end
    #1;
    chk("rst/gnt",      32'(gnt),      32'(0));
    chk("rst/rom_en",   32'(rom_en),   32'(0));
    chk("rst/rom_addr", 32'(rom_addr), 32'(0));
    chk("rst/rd_valid", 32'(rd_valid), 32'(0));
    chk("rst/rd_data",  32'(rd_data),  32'(0));
    req = 4'b0000;
    rst = 1'b1;

    // Single request from requester 2; data 12'hDCB three cycles later.
    step(4'b0100, 1'b0, 4'b0100, "single");
    idle(3, "single_drain");
    chk("single/rd_data_dcb", 32'(rd_data), 32'(12'hDCB));

    // Pointer is 3: search wraps to requester 0, then moves on to 1.
    step(4'b0011, 1'b0, 4'b0001, "wrap0");
    step(4'b0010, 1'b0, 4'b0010, "wrap1");
    step(4'b1000, 1'b0, 4'b1000, "align");

    // All four requesting: strict rotation, one grant per cycle.
    for (int i = 0; i < 8; i++) step(4'b1111, 1'b0, 4'(1 << (i % 4)), "rr_all");

    // Priority override starves 1..3; pointer then sits at 1.
    for (int i = 0; i < 6; i++) step(4'b1111, 1'b1, 4'b0001, "prio");
    step(4'b1110, 1'b0, 4'b0010, "post_prio");

    // Idle: returns drain, then rom_addr and rd_data hold.
    idle(5, "idle");

    // Withdrawn requests leave no trace; pointer unaffected (still 1).
    step(4'b1011, 1'b1, 4'b0001, "wd_prio");
    step(4'b0000, 1'b0, 4'b0000, "wd_drop");
    step(4'b1000, 1'b0, 4'b1000, "wd_next");
    idle(3, "wd_drain");

    // Reset with two reads in flight.
    step(4'b0001, 1'b0, 4'b0001, "inflight0");
    step(4'b0010, 1'b0, 4'b0010, "inflight1");
    req = 4'b0110;
    #2;
    rst = 1'b0;
    #1;
    chk("mid_rst/gnt",      32'(gnt),      32'(0));
    chk("mid_rst/rom_en",   32'(rom_en),   32'(0));
    chk("mid_rst/rom_addr", 32'(rom_addr), 32'(0));
    chk("mid_rst/rd_valid", 32'(rd_valid), 32'(0));
    chk("mid_rst/rd_data",  32'(rd_data),  32'(0));
    sb_q.delete();
    exp_en    = 1'b0;
    exp_addr  = '0;
    exp_rdata = '0;
    repeat (2) begin @(posedge clk); cyc++; end
    #1;
    chk("mid_rst_hold/rd_valid", 32'(rd_valid), 32'(0));
    req = 4'b0000;
    rst = 1'b1;
    idle(5, "post_rst_idle");

    // First grant after reset searches from requester 0.
    step(4'b1010, 1'b0, 4'b0010, "post_rst");
    idle(3, "final_drain");
    chk("sb_empty", 32'(sb_q.size()), 32'(0));

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/rom_port_arbiter.md
Name: rom_port_arbiter

Overview:
- Shares one single-port image ROM between up to N_REQ pixel/sprite fetch requesters, e.g. background, player, Kong and barrel layers feeding the scene compositor in front of the VGA driver.
- Each cycle it grants at most one request, drives the ROM address, and tracks the granted requester through the ROM read latency.
- It returns the ROM data tagged with a one-hot valid to the requester that issued the read.
- Arbitration is round-robin, with an optional strict-priority override for requester 0 (background) during active video.

Parameters:
- N_REQ, 4, number of requesters (2..8).
- ADDR_W, 16, ROM address width.
- DATA_W, 12, ROM data width (RGB444).
- ROM_LAT, 2, cycles from a registered rom_en/rom_addr to valid rom_data (1..4).

Ports:
- clk  in  1  system clock; all state changes on the rising edge.
- rst  in  1  asynchronous, active-low reset (0 = reset).
- req  in  N_REQ  per-requester read request; held with its address until granted.
- addr_in  in  N_REQ*ADDR_W  packed addresses; requester i uses bits [i*ADDR_W +: ADDR_W].
- prio_en  in  1  1 = requester 0 has absolute priority over all others.
- gnt  out  N_REQ  one-hot, combinational; req[i]&gnt[i] means the request is accepted this cycle.
- rom_en  out  1  registered ROM read enable.
- rom_addr  out  ADDR_W  registered ROM address.
- rom_data  in  DATA_W  ROM read data.
- rd_valid  out  N_REQ  registered one-hot return strobe.
- rd_data  out  DATA_W  registered return data, shared by all requesters.

Behaviour:
- Reset (rst=0, asynchronous): rom_en=0, rom_addr=0, rd_valid=0, rd_data=0, rr_ptr=0, tag pipeline cleared.
- gnt depends only on the current req, prio_en and rr_ptr. It is all zeros when req=0 or rst=0.
- Grant selection:
  - If prio_en=1 and req[0]=1, grant requester 0.
  - Otherwise grant the first set req bit searching rr_ptr, rr_ptr+1, … modulo N_REQ.
- Pointer update on a grant to requester k: rr_ptr <= (k+1) mod N_REQ.
  - This applies to priority grants as well.
  - No grant: rr_ptr holds.
- Issue stage (edge after acceptance):
  - rom_en <= 1, rom_addr <= addr_in of k, tag stage 0 <= one-hot k.
  - No grant: rom_en <= 0, rom_addr holds, tag <= 0.
- Tag pipeline: ROM_LAT registers shifted every cycle, unconditionally (no stall; the ROM never back-pressures).
- Return stage: rd_valid <= last tag stage, and rd_data <= rom_data when that tag is nonzero, otherwise rd_data holds.
- Latency:
  - Accept on cycle t → rom_en high at t+1 → rd_valid high at t+1+ROM_LAT.
  - Default ROM_LAT=2: t+3.
- Throughput: one accepted request per cycle, with back-to-back returns in grant order.
  - A requester may have up to ROM_LAT+1 reads in flight.
  - Results return in issue order.
- Requester rule: req and addr_in are held until gnt. The arbiter never drops an accepted request, and never accepts a request twice in one cycle.
- Deasserting req before grant withdraws the request cleanly, with no side effects.
- Reset mid-operation: in-flight reads are discarded, with no rd_valid after rst is released. The first post-reset grant starts search at requester 0.
- Invariants:
  - gnt and rd_valid are always one-hot or zero.
  - gnt ⊆ req.

Test Plan:
- Reset then single request: req=4'b0100, addr2=16'h1234, ROM model returns ~addr.
  - gnt=0100 same cycle; rom_en=1, rom_addr=16'h1234 next cycle.
  - rd_valid=0100, rd_data=12'hDCB three cycles after accept; rr_ptr=3.
- All four requesting continuously, prio_en=0:
  - Grant order 0,1,2,3,0,1,… with one grant per cycle.
  - rd_valid follows the same order delayed by 3 cycles, with no gaps.
- prio_en=1 with req=4'b1111 held 6 cycles: gnt=0001 every cycle and requesters 1–3 are starved.
  - After dropping req[0] with prio_en=0, the next grant is requester 1 (rr_ptr=1).
- Wrap-around: rr_ptr=3, req=4'b0011 → gnt=0001; following cycle with req=4'b0010 → gnt=0010.
- Reset asserted one cycle after two accepts (reads in flight):
  - All outputs reach zero immediately (async).
  - After release, no rd_valid pulses without new grants.
- Idle cycles: req=0 for 5 cycles → rom_en=0, rd_valid=0, rom_addr and rd_data hold their last values.
